// File: rtl/snn_pkg.sv
// Shared spiking-network definitions: neuron FSM encoding and default
// synaptic/neuron constants used by neurons, synapses and the network top.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_INTEGRATE  = 2'd0,
    ST_FIRE       = 2'd1,
    ST_REFRACTORY = 2'd2
  } snn_state_e;

  localparam int unsigned DEF_WEIGHT         = 64;
  localparam int unsigned DEF_THRESHOLD      = 200;
  localparam int unsigned DEF_LEAK_SHIFT     = 3;
  localparam int unsigned DEF_REFRACT_CYCLES = 4;
  localparam int unsigned REFR_CNT_W         = 4;

endpackage

// File: rtl/spike_rise_detect.sv
// Rising-edge detector for a synchronous spike level; the delayed copy is
// updated every clock so a held-high level yields exactly one rise.
module spike_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= in;
  end

  assign rise = in & ~r_q;

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: leaky saturating integrator with a
// one-clock fire pulse followed by a fixed refractory window.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned WEIGHT         = DEF_WEIGHT,
  parameter int unsigned THRESHOLD      = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT     = DEF_LEAK_SHIFT,
  parameter int unsigned REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             syn_spike,
  output logic             spike_out,
  output logic [WIDTH-1:0] membrane,
  output logic             refractory
);

  localparam logic [WIDTH:0]        ADD_W  = (WIDTH+1)'(WEIGHT);
  localparam logic [WIDTH-1:0]      THR_W  = WIDTH'(THRESHOLD);
  localparam logic [REFR_CNT_W-1:0] RLOAD  = REFR_CNT_W'(REFRACT_CYCLES - 1);

  snn_state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_membrane, w_mem_nxt;
  logic [REFR_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                  r_spike, w_spike_nxt;
  logic                  r_refr, w_refr_nxt;

  logic                  w_rise;
  logic [WIDTH-1:0]      w_leaked;
  logic [WIDTH:0]        w_sum;
  logic [WIDTH-1:0]      w_v_next;

  spike_rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (syn_spike),
    .rise (w_rise)
  );

  // Leak first, then add at WIDTH+1 bits so the carry selects saturation.
  assign w_leaked = r_membrane - (r_membrane >> LEAK_SHIFT);
  assign w_sum    = {1'b0, w_leaked} + (w_rise ? ADD_W : '0);
  assign w_v_next = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INTEGRATE;
      r_membrane <= '0;
      r_cnt      <= '0;
      r_spike    <= 1'b0;
      r_refr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_membrane <= w_mem_nxt;
      r_cnt      <= w_cnt_nxt;
      r_spike    <= w_spike_nxt;
      r_refr     <= w_refr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_nxt   = r_membrane;
    w_cnt_nxt   = r_cnt;
    w_spike_nxt = 1'b0;
    w_refr_nxt  = 1'b0;
    unique case (r_state)
      ST_INTEGRATE: begin
        if (en) begin
          if (w_v_next >= THR_W) begin
            w_state_nxt = ST_FIRE;
            w_mem_nxt   = '0;
            w_spike_nxt = 1'b1;
          end else begin
            w_mem_nxt   = w_v_next;
          end
        end
      end
      ST_FIRE: begin
        w_state_nxt = ST_REFRACTORY;
        w_mem_nxt   = '0;
        w_cnt_nxt   = RLOAD;
        w_refr_nxt  = 1'b1;
      end
      ST_REFRACTORY: begin
        w_mem_nxt = '0;
        if (r_cnt == '0) begin
          w_state_nxt = ST_INTEGRATE;
        end else begin
          w_cnt_nxt  = r_cnt - 1'b1;
          w_refr_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_INTEGRATE;
        w_mem_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign spike_out  = r_spike;
  assign membrane   = r_membrane;
  assign refractory = r_refr;

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: default instance plus a WEIGHT=200/THRESHOLD=255
// instance, both checked every cycle against an arithmetic neuron model.
module tb_lif_neuron;

  localparam int LS   = 3;
  localparam int R    = 4;
  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       syn = 1'b0;
  logic       spk1, refr1, spk2, refr2;
  logic [7:0] mem1, mem2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_neuron dut (
    .clk(clk), .rst(rst), .en(en), .syn_spike(syn),
    .spike_out(spk1), .membrane(mem1), .refractory(refr1)
  );

  lif_neuron #(.WEIGHT(200), .THRESHOLD(255)) dut2 (
    .clk(clk), .rst(rst), .en(en), .syn_spike(syn),
    .spike_out(spk2), .membrane(mem2), .refractory(refr2)
  );

  // left = clocks until integration resumes; R+1 right after a fire.
  typedef struct {
    int v;
    int left;
    bit prev;
  } mst_t;

  mst_t m1 = '{0, 0, 1'b0};
  mst_t m2 = '{0, 0, 1'b0};

  function automatic mst_t step(mst_t s, bit syn_i, bit en_i, int wt, int th);
    mst_t n = s;
    bit   rise = syn_i && !s.prev;
    int   nv;
    n.prev = syn_i;
    if (s.left > 0) begin
      n.left = s.left - 1;
    end else if (en_i) begin
      nv = s.v - (s.v >> LS) + (rise ? wt : 0);
      if (nv > MAXV) nv = MAXV;
      if (nv >= th) begin
        n.v    = 0;
        n.left = R + 1;
      end else begin
        n.v = nv;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 = '{0, 0, 1'b0};
      m2 = '{0, 0, 1'b0};
    end else begin
      m1 = step(m1, syn, en, 64, 200);
      m2 = step(m2, syn, en, 200, 255);
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("mem1",  int'(mem1),  m1.v);
    chk("spk1",  int'(spk1),  int'(m1.left == R + 1));
    chk("refr1", int'(refr1), int'(m1.left > 0 && m1.left <= R));
    chk("mem2",  int'(mem2),  m2.v);
    chk("spk2",  int'(spk2),  int'(m2.left == R + 1));
    chk("refr2", int'(refr2), int'(m2.left > 0 && m2.left <= R));
  end

  task automatic drive(bit s, bit e);
    syn = s;
    en  = e;
    @(negedge clk);
  endtask

  task automatic do_reset();
    syn = 1'b0;
    en  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int seq33[8] = '{64, 56, 113, 99, 151, 133, 181, 159};
  int seq32[5] = '{64, 56, 49, 43, 38};

  initial begin
    #1;
    syn = 1'b0;
    en  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem",  int'(mem1),  0);
    chk("rst_spk",  int'(spk1),  0);
    chk("rst_refr", int'(refr1), 0);
    rst = 1'b0;

    // single rise, accepted on the first edge after release
    drive(1'b1, 1'b1);
    chk("single_0", int'(mem1), seq32[0]);
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 1'b1);
      chk("single_leak", int'(mem1), seq32[i]);
    end

    // rise every 2 clocks to threshold, then rises during refractory
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i % 2 == 0, 1'b1);
      chk("train", int'(mem1), seq33[i]);
    end
    drive(1'b1, 1'b1);
    chk("fire_mem",  int'(mem1),  0);
    chk("fire_spk",  int'(spk1),  1);
    chk("fire_refr", int'(refr1), 0);
    for (int i = 0; i < 4; i++) begin
      drive(i % 2 == 1, 1'b1);
      chk("refr_on",  int'(refr1), 1);
      chk("refr_mem", int'(mem1),  0);
    end
    drive(1'b0, 1'b1);
    chk("refr_off",     int'(refr1), 0);
    chk("refr_off_mem", int'(mem1),  0);
    drive(1'b1, 1'b1);
    chk("post_refr_rise", int'(mem1), 64);

    // saturation on the large-weight instance
    do_reset();
    drive(1'b1, 1'b1);
    chk("sat_0", int'(mem2), 200);
    drive(1'b0, 1'b1);
    chk("sat_1", int'(mem2), 175);
    drive(1'b1, 1'b1);
    chk("sat_fire_mem", int'(mem2), 0);
    chk("sat_fire_spk", int'(spk2), 1);

    // held-high level and en=0 discarding a rise
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1);
      if (i == 0) chk("hold_first", int'(mem1), 64);
      if (i == 1) chk("hold_second", int'(mem1), 56);
    end
    chk("hold_last", int'(mem1), 21);
    drive(1'b0, 1'b1);
    chk("en_pre", int'(mem1), 19);
    drive(1'b1, 1'b0);
    chk("en_off_hold", int'(mem1), 19);
    drive(1'b1, 1'b1);
    chk("en_rise_lost", int'(mem1), 17);

    // async reset on the 2nd refractory clock
    do_reset();
    for (int i = 0; i < 9; i++) drive(i % 2 == 0, 1'b1);
    chk("abort_spk", int'(spk1), 1);
    drive(1'b0, 1'b1);
    chk("abort_refr1", int'(refr1), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_mem",  int'(mem1),  0);
    chk("async_spk",  int'(spk1),  0);
    chk("async_refr", int'(refr1), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1);
      chk("no_late_spk", int'(spk1), 0);
    end
    drive(1'b1, 1'b1);
    chk("after_abort_0", int'(mem1), 64);
    drive(1'b0, 1'b1);
    chk("after_abort_1", int'(mem1), 56);

    // randomized stimulus with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      syn = ($urandom_range(0, 99) < 40);
      en  = ($urandom_range(0, 9) != 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 8, membrane potential width in bits.
- REQ-002: The block SHALL have parameter WEIGHT, default 64, increment added per accepted synaptic spike.
- REQ-003: The block SHALL have parameter THRESHOLD, default 200, firing threshold, legal range 1..2^WIDTH-1.
- REQ-004: The block SHALL have parameter LEAK_SHIFT, default 3, leak as a right-shift amount, legal range 1..WIDTH-1.
- REQ-005: The block SHALL have parameter REFRACT_CYCLES, default 4, refractory length in clocks, legal range 1..15.
- REQ-006: The block SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
- REQ-007: The block SHALL have port rst, input, width 1, reset, asynchronous and active-high.
- REQ-008: The block SHALL have port en, input, width 1, integration enable.
- REQ-009: The block SHALL have port syn_spike, input, width 1, spike level from the delaying synapse output, synchronous to clk.
- REQ-010: The block SHALL have port spike_out, output, width 1, registered one-cycle fire pulse toward the next synapse's spike input.
- REQ-011: The block SHALL have port membrane, output, width WIDTH, registered membrane potential.
- REQ-012: The block SHALL have port refractory, output, width 1, high while in REFRACTORY.

Function
- REQ-013: The block SHALL register syn_spike into syn_q every clock, regardless of en or state; rise = syn_spike AND NOT syn_q.
- REQ-014: The block SHALL implement the FSM states INTEGRATE, FIRE and REFRACTORY.
- REQ-015: In INTEGRATE with en=1, the block SHALL update membrane each clock: v_next = v - (v >> LEAK_SHIFT) + (rise ? WEIGHT : 0).
- REQ-016: The add in v_next SHALL be computed at WIDTH+1 bits and saturated to 2^WIDTH-1; no wrap-around.
- REQ-017: Leak SHALL be applied before the add, so leak is zero once v < 2^LEAK_SHIFT and the membrane holds there.
- REQ-018: In INTEGRATE, if v_next >= THRESHOLD, the block SHALL go to FIRE and load membrane with 0; otherwise it SHALL stay in INTEGRATE and load membrane with v_next.
- REQ-019: In INTEGRATE with en=0, membrane and state SHALL hold, and rises occurring that cycle SHALL be discarded.
- REQ-020: FIRE SHALL last exactly one clock, with spike_out=1.
- REQ-021: spike_out SHALL rise one clock after the edge at which the threshold is crossed, and the block SHALL then go to REFRACTORY.
- REQ-022: REFRACTORY SHALL last exactly REFRACT_CYCLES clocks, with membrane held at 0, refractory=1, and all rises ignored.
- REQ-023: After REFRACTORY the block SHALL return to INTEGRATE.
- REQ-024: en SHALL NOT stall FIRE or REFRACTORY.
- REQ-025: A syn_spike held high SHALL produce exactly one rise; a rise that lands on the final REFRACTORY clock SHALL be dropped.

Reset
- REQ-026: rst=1 SHALL immediately, without waiting for clk, force state to INTEGRATE, membrane to 0, syn_q to 0, the refractory counter to 0, and spike_out and refractory to 0.
- REQ-027: Reset asserted mid-FIRE or mid-REFRACTORY SHALL abort it, and no spike_out pulse SHALL appear after release.
- REQ-028: The first rise SHALL be accepted on the first clock edge after rst deasserts.

Structure
- REQ-029: Shared package snn_pkg SHALL hold the FSM state encoding and the default WEIGHT, THRESHOLD, LEAK_SHIFT and REFRACT_CYCLES constants, which are also used by the synapse and network top.
- REQ-030: Sub-module spike_rise_detect (clk, rst, in -> rise) SHALL implement REQ-013 and be reusable by other spike consumers.
- REQ-031: The refractory counter SHALL be 4 bits, down-counting.

Verification (defaults unless stated)
- REQ-032: Single rise from reset -> membrane 64, then 56, 49, 43, 38 on successive clocks; spike_out stays 0.
- REQ-033: A rise every 2 clocks -> membrane 64, 56, 113, 99, 151, 133, 181, 159; the 5th rise gives v_next=204, so membrane=0, spike_out=1 for one clock, then refractory=1 for exactly 4 clocks.
- REQ-034: Rises every 2 clocks during REFRACTORY -> membrane stays 0; the first increment to 64 occurs only on a rise after refractory falls.
- REQ-035: WEIGHT=200, THRESHOLD=255, two rises 2 clocks apart -> membrane 200, 175, then saturated 255, so the block fires with no wrap to 98.
- REQ-036: syn_spike held high 10 clocks -> exactly one +64; with en=0 during the rise -> membrane unchanged, and that rise is lost after en returns.
- REQ-037: rst pulsed on the 2nd REFRACTORY clock -> all outputs 0 asynchronously, no further spike_out, and a normal single-rise response after release.
